// File: rtl/shift_sequencer.sv
// Multicycle sequencer for the datapath shifter and its write-back into ALUOut.
// Outputs are decoded from the state register and the operands latched at acceptance.
module shift_sequencer #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [SHAMT_W-1:0] rs_amt,
    output logic [2:0]         shifter_ctrl,
    output logic [SHAMT_W-1:0] shifter_n,
    output logic               m_shifter,
    output logic [1:0]         m_aluout,
    output logic               aluout_we,
    output logic               busy,
    output logic               done,
    output logic               illegal
);

    if (SHAMT_W != $clog2(DATA_W)) begin : g_width_check
        $error("SHAMT_W must equal log2(DATA_W)");
    end

    localparam logic [2:0] OP_SLL  = 3'b000;
    localparam logic [2:0] OP_SRL  = 3'b001;
    localparam logic [2:0] OP_SRA  = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SLLV = 3'b100;
    localparam logic [2:0] OP_SRAV = 3'b101;

    localparam logic [2:0] SH_HOLD = 3'b000;
    localparam logic [2:0] SH_LOAD = 3'b001;
    localparam logic [2:0] SH_SLL  = 3'b010;
    localparam logic [2:0] SH_SRL  = 3'b011;
    localparam logic [2:0] SH_SRA  = 3'b100;

    localparam logic [SHAMT_W-1:0] LUI_AMT = SHAMT_W'(16);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        WB    = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t             state, state_next;
    logic [2:0]         op_q;
    logic [SHAMT_W-1:0] amt_q;
    logic [SHAMT_W-1:0] amt_sel;
    logic               op_illegal;
    logic               accept;

    assign op_illegal = (op[2:1] == 2'b11);
    assign accept     = (state == IDLE) && start;

    always_comb begin
        amt_sel = shamt;
        if (op == OP_LUI) begin
            amt_sel = LUI_AMT;
        end else if (op == OP_SLLV || op == OP_SRAV) begin
            amt_sel = rs_amt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            op_q  <= 3'b000;
            amt_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q  <= op;
                amt_q <= amt_sel;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = op_illegal ? ERR : LOAD;
            LOAD:    state_next = (amt_q == '0) ? WB : SHIFT;
            SHIFT:   state_next = WB;
            WB:      state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Mux selection for LUI is held from LOAD through WB so the shifter keeps its source.
    always_comb begin
        shifter_ctrl = SH_HOLD;
        shifter_n    = '0;
        m_shifter    = 1'b0;
        m_aluout     = 2'b00;
        aluout_we    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        illegal      = 1'b0;
        case (state)
            LOAD: begin
                shifter_ctrl = SH_LOAD;
                shifter_n    = amt_q;
                m_shifter    = (op_q == OP_LUI);
                busy         = 1'b1;
            end
            SHIFT: begin
                case (op_q)
                    OP_SLL, OP_SLLV, OP_LUI: shifter_ctrl = SH_SLL;
                    OP_SRL:                  shifter_ctrl = SH_SRL;
                    OP_SRA, OP_SRAV:         shifter_ctrl = SH_SRA;
                    default:                 shifter_ctrl = SH_HOLD;
                endcase
                shifter_n = amt_q;
                m_shifter = (op_q == OP_LUI);
                busy      = 1'b1;
            end
            WB: begin
                shifter_n = amt_q;
                m_shifter = (op_q == OP_LUI);
                m_aluout  = 2'b10;
                aluout_we = 1'b1;
                busy      = 1'b1;
                done      = 1'b1;
            end
            ERR: begin
                shifter_n = amt_q;
                busy      = 1'b1;
                done      = 1'b1;
                illegal   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: expected per-cycle output vectors are queued
// when a request is driven and compared as the sequencer steps through its states.
module tb_shift_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [4:0] shamt;
    logic [4:0] rs_amt;
    logic [2:0] shifter_ctrl;
    logic [4:0] shifter_n;
    logic       m_shifter;
    logic [1:0] m_aluout;
    logic       aluout_we;
    logic       busy;
    logic       done;
    logic       illegal;

    int n_checks = 0;
    int n_pass   = 0;

    logic [14:0] sb[$];

    shift_sequencer #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .shamt(shamt), .rs_amt(rs_amt),
        .shifter_ctrl(shifter_ctrl), .shifter_n(shifter_n), .m_shifter(m_shifter),
        .m_aluout(m_aluout), .aluout_we(aluout_we), .busy(busy), .done(done), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] pk(logic [2:0] c, logic [4:0] n, logic ms, logic [1:0] ma,
                                       logic we, logic bsy, logic dn, logic il);
        return {c, n, ms, ma, we, bsy, dn, il};
    endfunction

    function automatic logic [14:0] got_vec();
        return {shifter_ctrl, shifter_n, m_shifter, m_aluout, aluout_we, busy, done, illegal};
    endfunction

    // Reference: one vector per cycle after acceptance, ending with the IDLE cycle.
    task automatic push_req(input logic [2:0] o, input logic [4:0] sa, input logic [4:0] ra);
        logic [4:0] amt;
        logic       ms;
        logic [2:0] ctrl;
        if (o == 3'b011)                     amt = 5'd16;
        else if (o == 3'b100 || o == 3'b101) amt = ra;
        else                                 amt = sa;
        if (o == 3'b110 || o == 3'b111) begin
            sb.push_back(pk(3'b000, amt, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1));
        end else begin
            ms = (o == 3'b011);
            sb.push_back(pk(3'b001, amt, ms, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
            if (amt != 5'd0) begin
                if (o == 3'b000 || o == 3'b100 || o == 3'b011) ctrl = 3'b010;
                else if (o == 3'b001)                          ctrl = 3'b011;
                else                                           ctrl = 3'b100;
                sb.push_back(pk(ctrl, amt, ms, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
            end
            sb.push_back(pk(3'b000, amt, ms, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0));
        end
        sb.push_back(15'h0);
    endtask

    task automatic test_reset();
        logic [14:0] g;
        reset = 1'b1; start = 1'b0; op = 3'b000; shamt = 5'd0; rs_amt = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        g = got_vec(); n_checks++;
        if (g !== 15'h0) $display("FAIL reset_state: got %h expected %h", g, 15'h0);
        else n_pass++;
        start = 1'b1; shamt = 5'd4;
        @(posedge clk); #1;
        g = got_vec(); n_checks++;
        if (g !== 15'h0) $display("FAIL reset_priority: got %h expected %h", g, 15'h0);
        else n_pass++;
        start = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_sll();
        logic [14:0] e, g;
        push_req(3'b000, 5'd4, 5'd0);
        start = 1'b1; op = 3'b000; shamt = 5'd4;
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            start = 1'b0;
            e = sb.pop_front(); g = got_vec(); n_checks++;
            if (g !== e) $display("FAIL sll: got %h expected %h", g, e);
            else n_pass++;
        end
    endtask

    task automatic test_lui();
        logic [14:0] e, g;
        push_req(3'b011, 5'd7, 5'd0);
        start = 1'b1; op = 3'b011; shamt = 5'd7;
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            start = 1'b0;
            e = sb.pop_front(); g = got_vec(); n_checks++;
            if (g !== e) $display("FAIL lui: got %h expected %h", g, e);
            else n_pass++;
        end
    endtask

    task automatic test_srav();
        logic [14:0] e, g;
        push_req(3'b101, 5'd9, 5'd31);
        start = 1'b1; op = 3'b101; shamt = 5'd9; rs_amt = 5'd31;
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            start = 1'b0; rs_amt = 5'd3; op = 3'b001; shamt = 5'd1;
            e = sb.pop_front(); g = got_vec(); n_checks++;
            if (g !== e) $display("FAIL srav: got %h expected %h", g, e);
            else n_pass++;
        end
    endtask

    task automatic test_zero_amt();
        logic [14:0] e, g;
        push_req(3'b001, 5'd0, 5'd0);
        start = 1'b1; op = 3'b001; shamt = 5'd0;
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            start = 1'b0;
            e = sb.pop_front(); g = got_vec(); n_checks++;
            if (g !== e) $display("FAIL zero_amt: got %h expected %h", g, e);
            else n_pass++;
        end
    endtask

    task automatic test_illegal();
        logic [14:0] e, g;
        for (int k = 6; k <= 7; k++) begin
            push_req(3'(k), 5'd3, 5'd0);
            start = 1'b1; op = 3'(k); shamt = 5'd3;
            while (sb.size() > 0) begin
                @(posedge clk); #1;
                start = 1'b0;
                e = sb.pop_front(); g = got_vec(); n_checks++;
                if (g !== e) $display("FAIL illegal_op%0d: got %h expected %h", k, g, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_abort();
        logic [14:0] e, g;
        start = 1'b1; op = 3'b000; shamt = 5'd2;
        @(posedge clk); #1;
        op = 3'b001; shamt = 5'd5;
        e = pk(3'b001, 5'd2, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0); g = got_vec(); n_checks++;
        if (g !== e) $display("FAIL abort_load: got %h expected %h", g, e);
        else n_pass++;
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b1;
        e = pk(3'b010, 5'd2, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0); g = got_vec(); n_checks++;
        if (g !== e) $display("FAIL abort_ignored_start: got %h expected %h", g, e);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        g = got_vec(); n_checks++;
        if (g !== 15'h0) $display("FAIL abort_reset: got %h expected %h", g, 15'h0);
        else n_pass++;
        push_req(3'b000, 5'd2, 5'd0);
        start = 1'b1; op = 3'b000; shamt = 5'd2;
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            start = 1'b0;
            e = sb.pop_front(); g = got_vec(); n_checks++;
            if (g !== e) $display("FAIL abort_restart: got %h expected %h", g, e);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] e, g;
        push_req(3'b000, 5'd1, 5'd0);
        push_req(3'b010, 5'd0, 5'd0);
        start = 1'b1; op = 3'b000; shamt = 5'd1;
        for (int c = 1; sb.size() > 0; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin op = 3'b010; shamt = 5'd0; end
            if (sb.size() == 1) start = 1'b0;
            e = sb.pop_front(); g = got_vec(); n_checks++;
            if (g !== e) $display("FAIL back_to_back_c%0d: got %h expected %h", c, g, e);
            else n_pass++;
        end
        start = 1'b0;
        @(posedge clk); #1;
        g = got_vec(); n_checks++;
        if (g !== 15'h0) $display("FAIL back_to_back_idle: got %h expected %h", g, 15'h0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sll();
        test_lui();
        test_srav();
        test_zero_amt();
        test_illegal();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
